// File: rtl/ascon_pack.sv
// Shared constants and state encoding for the ASCON output collector.
package ascon_pack;

  localparam int unsigned CIPHER_W       = 64;
  localparam int unsigned TAG_W          = 128;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = CIPHER_W / BYTE_W;
  localparam int unsigned TAG_BYTES      = TAG_W / BYTE_W;

  typedef enum logic [1:0] {
    COLLECT     = 2'd0,
    SEND_CIPHER = 2'd1,
    SEND_TAG    = 2'd2,
    DONE        = 2'd3
  } coll_state_e;

endpackage

// File: rtl/byte_serializer.sv
// Registered byte output stage; holds data/valid until the consumer accepts.
module byte_serializer
  import ascon_pack::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              ready_i,
  output logic [BYTE_W-1:0] data_o,
  output logic              valid_o,
  output logic              xfer_c
);

  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  assign xfer_c  = valid_q & ready_i;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  // A load always coincides with a transfer or an idle slot, so it never overwrites a pending byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (xfer_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/ascon_output_collector.sv
// Captures ASCON ciphertext words and tag, then streams them out byte-wise MSB first.
module ascon_output_collector
  import ascon_pack::*;
#(
  parameter int unsigned NB_CIPHER_WORDS = 3
) (
  input  logic                clock_i,
  input  logic                resetb_i,
  input  logic                start_i,
  input  logic                cipher_valid_i,
  input  logic [CIPHER_W-1:0] cipher_i,
  input  logic                end_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic [BYTE_W-1:0]   out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o
);

  localparam int unsigned WR_W = $clog2(NB_CIPHER_WORDS + 1);
  localparam int unsigned RD_W = $clog2(BYTES_PER_WORD * NB_CIPHER_WORDS + TAG_BYTES);
  localparam int unsigned WI_W = RD_W - 3;

  coll_state_e       state_q, state_d;
  logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [RD_W-1:0]   rd_byte_q, rd_byte_d;
  logic              cipher_valid_q;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CIPHER_W-1:0] word_q [NB_CIPHER_WORDS];
  logic [TAG_W-1:0]    tag_q;

  logic              cap_c;
  logic              word_we_c, tag_we_c;
  logic [WR_W-1:0]   wr_idx_c;
  logic              load_c, clear_c, xfer_c;
  logic [BYTE_W-1:0] load_byte_c;
  logic [RD_W-1:0]   nxt_idx_c, last_cbyte_c;
  logic [CIPHER_W-1:0] sel_word_c;
  logic [BYTE_W-1:0] cipher_byte_c, tag_byte_c;

  assign cap_c = cipher_valid_i & ~cipher_valid_q;

  // Byte that follows the one currently presented.
  always_comb begin
    nxt_idx_c  = rd_byte_q + RD_W'(1);
    sel_word_c = '0;
    for (int unsigned w = 0; w < NB_CIPHER_WORDS; w++) begin
      if (nxt_idx_c[RD_W-1:3] == WI_W'(w)) sel_word_c = word_q[w];
    end
    cipher_byte_c = BYTE_W'(sel_word_c >> {~nxt_idx_c[2:0], 3'b000});
    tag_byte_c    = BYTE_W'(tag_q >> {~nxt_idx_c[3:0], 3'b000});
    last_cbyte_c  = RD_W'(BYTES_PER_WORD) * RD_W'(wr_cnt_q) - RD_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_byte_d   = rd_byte_q;
    overflow_d  = overflow_q;
    word_we_c   = 1'b0;
    tag_we_c    = 1'b0;
    wr_idx_c    = wr_cnt_q;
    load_c      = 1'b0;
    load_byte_c = '0;
    clear_c     = 1'b0;

    if (start_i) begin
      state_d    = COLLECT;
      wr_cnt_d   = '0;
      rd_byte_d  = '0;
      overflow_d = 1'b0;
      clear_c    = 1'b1;
      wr_idx_c   = '0;
      if (cap_c) begin
        word_we_c = 1'b1;
        wr_cnt_d  = WR_W'(1);
      end
    end else begin
      case (state_q)
        COLLECT: begin
          if (cap_c) begin
            if (wr_cnt_q < WR_W'(NB_CIPHER_WORDS)) begin
              word_we_c = 1'b1;
              wr_cnt_d  = wr_cnt_q + WR_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
          // A word captured this same cycle is not yet in storage, so bypass it.
          if (end_i) begin
            tag_we_c  = 1'b1;
            rd_byte_d = '0;
            load_c    = 1'b1;
            if (wr_cnt_d != '0) begin
              state_d     = SEND_CIPHER;
              load_byte_c = (wr_cnt_q == '0) ? cipher_i[CIPHER_W-1 -: BYTE_W]
                                             : word_q[0][CIPHER_W-1 -: BYTE_W];
            end else begin
              state_d     = SEND_TAG;
              load_byte_c = tag_i[TAG_W-1 -: BYTE_W];
            end
          end
        end
        SEND_CIPHER: begin
          if (cap_c || end_i) overflow_d = 1'b1;
          if (xfer_c) begin
            load_c = 1'b1;
            if (rd_byte_q == last_cbyte_c) begin
              state_d     = SEND_TAG;
              rd_byte_d   = '0;
              load_byte_c = tag_q[TAG_W-1 -: BYTE_W];
            end else begin
              rd_byte_d   = nxt_idx_c;
              load_byte_c = cipher_byte_c;
            end
          end
        end
        SEND_TAG: begin
          if (cap_c || end_i) overflow_d = 1'b1;
          if (xfer_c) begin
            if (rd_byte_q == RD_W'(TAG_BYTES - 1)) begin
              state_d = DONE;
            end else begin
              rd_byte_d   = nxt_idx_c;
              load_c      = 1'b1;
              load_byte_c = tag_byte_c;
            end
          end
        end
        DONE: begin
          if (cap_c || end_i) overflow_d = 1'b1;
          state_d   = COLLECT;
          wr_cnt_d  = '0;
          rd_byte_d = '0;
        end
        default: state_d = COLLECT;
      endcase
    end

    busy_d = (state_d == SEND_CIPHER) || (state_d == SEND_TAG);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= COLLECT;
      wr_cnt_q       <= '0;
      rd_byte_q      <= '0;
      cipher_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_byte_q      <= rd_byte_d;
      cipher_valid_q <= cipher_valid_i;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Payload storage carries no reset; it is always written before it is read.
  always_ff @(posedge clock_i) begin
    if (tag_we_c) tag_q <= tag_i;
    for (int unsigned w = 0; w < NB_CIPHER_WORDS; w++) begin
      if (word_we_c && (wr_idx_c == WR_W'(w))) word_q[w] <= cipher_i;
    end
  end

  byte_serializer u_ser (
    .clk     (clock_i),
    .rst_n   (resetb_i),
    .clear_i (clear_c),
    .load_i  (load_c),
    .data_i  (load_byte_c),
    .ready_i (out_ready_i),
    .data_o  (out_data_o),
    .valid_o (out_valid_o),
    .xfer_c  (xfer_c)
  );

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ascon_output_collector.sv
// Randomized and directed bench for ascon_output_collector against a queue-based byte-stream model.
module tb_ascon_output_collector;
  import ascon_pack::*;

  localparam int unsigned NB = 3;

  logic                clock_i = 1'b0;
  logic                resetb_i, start_i, cipher_valid_i, end_i, out_ready_i;
  logic [CIPHER_W-1:0] cipher_i;
  logic [TAG_W-1:0]    tag_i;
  logic [7:0]          out_data_o;
  logic                out_valid_o, busy_o, done_o, overflow_o;

  ascon_output_collector #(.NB_CIPHER_WORDS(NB)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
    .cipher_valid_i(cipher_valid_i), .cipher_i(cipher_i), .end_i(end_i), .tag_i(tag_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, ready_mode = 0, rcnt = 0;
  bit chk_en = 0;

  // Reference model: pending output bytes as a queue.
  logic [63:0] m_words[$];
  logic [7:0]  m_stream[$];
  bit m_sending = 0, m_done = 0, m_ovf = 0, m_prev = 0;

  logic [7:0] log_q[$];
  int first_cyc = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0;
  bit p_stall = 0;
  logic [7:0] p_data = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_words.delete(); m_stream.delete();
    m_sending = 0; m_done = 0; m_ovf = 0; m_prev = 0;
  endtask

  task automatic model_step();
    bit cap, xfer;
    cap    = cipher_valid_i && !m_prev;
    m_prev = cipher_valid_i;
    xfer   = m_sending && out_ready_i;
    if (start_i) begin
      m_words.delete(); m_stream.delete();
      m_sending = 0; m_done = 0; m_ovf = 0;
      if (cap) m_words.push_back(cipher_i);
    end else if (m_sending) begin
      if (cap || end_i) m_ovf = 1;
      if (xfer) begin
        void'(m_stream.pop_front());
        if (m_stream.size() == 0) begin m_sending = 0; m_done = 1; end
      end
    end else if (m_done) begin
      if (cap || end_i) m_ovf = 1;
      m_done = 0;
      m_words.delete();
    end else begin
      if (cap) begin
        if (m_words.size() < NB) m_words.push_back(cipher_i);
        else m_ovf = 1;
      end
      if (end_i) begin
        m_stream.delete();
        foreach (m_words[i])
          for (int b = 0; b < 8; b++) m_stream.push_back(m_words[i][63-8*b -: 8]);
        for (int b = 0; b < 16; b++) m_stream.push_back(tag_i[127-8*b -: 8]);
        m_sending = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clock_i or negedge resetb_i);
    if (!resetb_i) model_reset();
    else model_step();
  end

  initial forever begin
    @(posedge clock_i);
    cyc++;
  end

  // Compare process: outputs sampled mid-cycle.
  initial forever begin
    @(negedge clock_i);
    if (chk_en) begin
      chk("valid", out_valid_o, m_sending);
      chk("busy", busy_o, m_sending);
      chk("done", done_o, m_done);
      chk("overflow", overflow_o, m_ovf);
      if (m_sending) chk("data", out_data_o, (m_stream.size() > 0) ? m_stream[0] : 8'hxx);
      if (p_stall) begin
        chk("hold_data", out_data_o, p_data);
        chk("hold_valid", out_valid_o, 1'b1);
      end
    end
    p_stall = out_valid_o && !out_ready_i;
    p_data  = out_data_o;
    if (out_valid_o && out_ready_i) begin
      log_q.push_back(out_data_o);
      if (log_q.size() == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (done_o) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
    case (ready_mode)
      0: out_ready_i = 1'b1;
      1: begin out_ready_i = (rcnt % 4 == 0) || (rcnt % 4 == 3); rcnt++; end
      default: out_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cap_word(input logic [63:0] w, input int hold);
    cipher_valid_i = 1; cipher_i = w;
    tick();
    for (int i = 1; i < hold; i++) begin cipher_i = rnd64(); tick(); end
    cipher_valid_i = 0; cipher_i = rnd64();
    tick();
  endtask

  task automatic fire_end(input logic [127:0] t);
    end_i = 1; tag_i = t;
    tick();
    end_i = 0; tag_i = rnd128();
  endtask

  task automatic do_start();
    start_i = 1; tick(); start_i = 0; tick();
    log_q.delete();
  endtask

  task automatic wait_done(input int mark, input int budget, input string nm);
    int k = 0;
    while (done_cnt == mark && k < budget) begin tick(); k++; end
    if (done_cnt == mark) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout, done_o not seen in %0d cycles", nm, budget);
    end
    tick();
  endtask

  initial begin
    logic [63:0]  w0, w1, w2;
    logic [127:0] t;
    int mark, nw, k;
    resetb_i = 0; start_i = 0; cipher_valid_i = 0; end_i = 0;
    cipher_i = '0; tag_i = '0; out_ready_i = 0;
    repeat (3) tick();
    chk_en = 1;
    chk("rst_data", out_data_o, 8'h00);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    resetb_i = 1; tick();

    // Three words then tag, consumer always ready.
    do_start();
    mark = done_cnt;
    cap_word(64'h0123456789ABCDEF, 1);
    cap_word(64'h1111111111111111, 1);
    cap_word(64'h2222222222222222, 1);
    fire_end(128'h00112233445566778899AABBCCDDEEFF);
    wait_done(mark, 200, "t1_done");
    chk("t1_len", 128'(log_q.size()), 128'd40);
    chk("t1_b0", log_q[0], 8'h01);
    chk("t1_b1", log_q[1], 8'h23);
    chk("t1_b7", log_q[7], 8'hEF);
    chk("t1_b8", log_q[8], 8'h11);
    chk("t1_b16", log_q[16], 8'h22);
    chk("t1_b24", log_q[24], 8'h00);
    chk("t1_b25", log_q[25], 8'h11);
    chk("t1_b39", log_q[39], 8'hFF);
    chk("t1_consecutive", 128'(last_cyc - first_cyc), 128'd39);
    chk("t1_done_lat", 128'(done_cyc), 128'(last_cyc + 1));

    // Level held for five cycles gives one capture.
    do_start();
    mark = done_cnt;
    w0 = rnd64();
    cap_word(w0, 5);
    fire_end(rnd128());
    wait_done(mark, 200, "t2_done");
    chk("t2_len", 128'(log_q.size()), 128'd24);
    chk("t2_b0", log_q[0], w0[63:56]);

    // Ready pattern 1,0,0,1.
    do_start();
    ready_mode = 1; rcnt = 0;
    mark = done_cnt;
    w0 = rnd64(); w1 = rnd64(); w2 = rnd64();
    cap_word(w0, 1); cap_word(w1, 2); cap_word(w2, 1);
    t = rnd128();
    fire_end(t);
    wait_done(mark, 400, "t3_done");
    chk("t3_len", 128'(log_q.size()), 128'd40);
    chk("t3_b9", log_q[9], w1[55:48]);
    chk("t3_b39", log_q[39], t[7:0]);
    ready_mode = 0;

    // Fourth capture overflows.
    do_start();
    mark = done_cnt;
    w0 = rnd64(); w1 = rnd64(); w2 = rnd64();
    cap_word(w0, 1); cap_word(w1, 1); cap_word(w2, 1);
    chk("t4_ovf_before", overflow_o, 1'b0);
    cipher_valid_i = 1; cipher_i = rnd64();
    tick();
    chk("t4_ovf_after", overflow_o, 1'b1);
    cipher_valid_i = 0; tick();
    fire_end(rnd128());
    wait_done(mark, 200, "t4_done");
    chk("t4_len", 128'(log_q.size()), 128'd40);
    chk("t4_b0", log_q[0], w0[63:56]);
    chk("t4_b23", log_q[23], w2[7:0]);
    chk("t4_ovf_kept", overflow_o, 1'b1);
    start_i = 1; tick(); start_i = 0;
    chk("t4_ovf_cleared", overflow_o, 1'b0);
    tick();

    // Capture and end in the same cycle with no prior words.
    do_start();
    mark = done_cnt;
    w0 = rnd64(); t = rnd128();
    cipher_valid_i = 1; cipher_i = w0; end_i = 1; tag_i = t;
    tick();
    cipher_valid_i = 0; end_i = 0; cipher_i = rnd64();
    wait_done(mark, 200, "t5_done");
    chk("t5_len", 128'(log_q.size()), 128'd24);
    chk("t5_b0", log_q[0], w0[63:56]);
    chk("t5_b8", log_q[8], t[127:120]);

    // End with no captures: tag only.
    do_start();
    mark = done_cnt;
    t = rnd128();
    fire_end(t);
    wait_done(mark, 200, "t6_done");
    chk("t6_len", 128'(log_q.size()), 128'd16);
    chk("t6_b0", log_q[0], t[127:120]);

    // Capture in the same cycle as start lands in word 0.
    w0 = rnd64();
    start_i = 1; cipher_valid_i = 1; cipher_i = w0;
    tick();
    start_i = 0; cipher_valid_i = 0;
    log_q.delete();
    mark = done_cnt;
    fire_end(rnd128());
    wait_done(mark, 200, "t7_done");
    chk("t7_len", 128'(log_q.size()), 128'd24);
    chk("t7_b0", log_q[0], w0[63:56]);

    // Reset in the middle of a stream.
    do_start();
    cap_word(rnd64(), 1); cap_word(rnd64(), 1); cap_word(rnd64(), 1);
    fire_end(rnd128());
    k = 0;
    while (log_q.size() < 10 && k < 100) begin tick(); k++; end
    chk("t8_reached_b10", 128'(log_q.size()), 128'd10);
    resetb_i = 0;
    #1;
    chk("t8_data0", out_data_o, 8'h00);
    chk("t8_valid0", out_valid_o, 1'b0);
    chk("t8_busy0", busy_o, 1'b0);
    chk("t8_done0", done_o, 1'b0);
    tick(); tick();
    resetb_i = 1; tick();
    log_q.delete();
    mark = done_cnt;
    w0 = rnd64();
    cap_word(w0, 2); cap_word(rnd64(), 1);
    fire_end(rnd128());
    wait_done(mark, 200, "t8_done");
    chk("t8_len", 128'(log_q.size()), 128'd32);
    chk("t8_b0", log_q[0], w0[63:56]);

    // Random messages with random ready and occasional late captures.
    for (int it = 0; it < 25; it++) begin
      do_start();
      ready_mode = int'($urandom_range(0, 2));
      nw = int'($urandom_range(0, 4));
      for (int i = 0; i < nw; i++) begin
        cap_word(rnd64(), int'($urandom_range(1, 4)));
        repeat ($urandom_range(0, 2)) tick();
      end
      mark = done_cnt;
      fire_end(rnd128());
      if ($urandom_range(0, 3) == 0) begin
        tick(); tick();
        cap_word(rnd64(), 1);
      end
      wait_done(mark, 600, "rnd_done");
      chk("rnd_len", 128'(log_q.size()), 128'(8 * ((nw > 3) ? 3 : nw) + 16));
    end
    ready_mode = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
